// File: rtl/core_mon_pkg.sv
// Shared types and trace-entry layout for the core run monitor.
// An entry packs {run, ts, data} with data in the low bits.
package core_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int RUN_W = 8;

    function automatic int entry_w(input int ts_w, input int data_w);
        return RUN_W + ts_w + data_w;
    endfunction

    function automatic int ts_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int run_lsb(input int ts_w, input int data_w);
        return data_w + ts_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers and a synchronous clear.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // When full, the write slot equals the head being popped; the head is read before it is overwritten.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/core_run_monitor.sv
// Sequences the core through N_RUNS reset/run episodes and traces every change
// of core_data into a timestamped FIFO.
module core_run_monitor
    import core_mon_pkg::*;
#(
    parameter int DATA_W     = 6,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 16,
    parameter int RST_CYCLES = 2,
    parameter int RUN_CYCLES = 50,
    parameter int N_RUNS     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              core_nrst,
    input  logic [DATA_W-1:0] core_data,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [TS_W-1:0]   rd_ts,
    output logic [7:0]        rd_run,
    output logic              overflow
);
    localparam int ENTRY_W = entry_w(TS_W, DATA_W);
    localparam int TS_LSB  = ts_lsb(DATA_W);
    localparam int RUN_LSB = run_lsb(TS_W, DATA_W);
    localparam int CNT_MAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [TS_W-1:0] TS_SAT = '1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         run;
    logic [TS_W-1:0]    ts;
    logic [DATA_W-1:0]  prev;
    logic               hold_end, run_end, last_run, clr, push;
    logic               full, empty, pop;
    logic [ENTRY_W-1:0] wdata, rdata;

    assign hold_end = (state == HOLD) && (cnt == CNT_W'(RST_CYCLES - 1));
    assign run_end  = (state == RUN)  && (cnt == CNT_W'(RUN_CYCLES - 1));
    assign last_run = (run == 8'(N_RUNS - 1));
    assign clr      = (state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        core_nrst = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_n = HOLD;
            HOLD: begin
                busy = 1'b1;
                if (hold_end) state_n = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                core_nrst = 1'b1;
                if (run_end) state_n = last_run ? DONE : HOLD;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // cnt times both the hold and the run phase; it restarts at every phase boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            run <= '0;
            ts  <= '0;
        end else begin
            if (clr || hold_end || run_end || state == IDLE || state == DONE) cnt <= '0;
            else                                                           cnt <= cnt + CNT_W'(1);
            if (clr)                      run <= '0;
            else if (run_end && !last_run) run <= run + 8'd1;
            if (state == RUN && !run_end) ts <= (ts == TS_SAT) ? ts : ts + TS_W'(1);
            else                          ts <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                prev <= '0;
        else if (state == RUN)  prev <= core_data;
    end

    assign push  = (state == RUN) && ((cnt == '0) || (core_data != prev));
    assign wdata = {run, ts, core_data};
    assign pop   = rd_ready && rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       overflow <= 1'b0;
        else if (clr)                  overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
    end

    trace_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .push (push),
        .wdata(wdata),
        .full (full),
        .pop  (pop),
        .rdata(rdata),
        .empty(empty)
    );

    assign rd_valid = !empty;
    assign rd_data  = rdata[DATA_W-1:0];
    assign rd_ts    = rdata[TS_LSB +: TS_W];
    assign rd_run   = rdata[RUN_LSB +: RUN_W];

endmodule

// File: tb/tb_core_run_monitor.sv
// Directed bench for core_run_monitor: default, DEPTH=4, and TS_W=4/RUN_CYCLES=20 instances.
module tb_core_run_monitor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start0, rdy0, nrst0, busy0, done0, v0, ov0;
    logic [5:0] data0, d0;
    logic [15:0] ts0;
    logic [7:0] run0;
    logic       start1, rdy1, nrst1, busy1, done1, v1, ov1;
    logic [5:0] data1, d1;
    logic [15:0] ts1;
    logic [7:0] run1;
    logic       start2, rdy2, nrst2, busy2, done2, v2, ov2;
    logic [5:0] data2, d2;
    logic [3:0] ts2;
    logic [7:0] run2;

    core_run_monitor dut0 (
        .clk(clk), .rst(rst), .start(start0), .core_nrst(nrst0), .core_data(data0),
        .busy(busy0), .done(done0), .rd_valid(v0), .rd_ready(rdy0), .rd_data(d0),
        .rd_ts(ts0), .rd_run(run0), .overflow(ov0));

    core_run_monitor #(.DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .core_nrst(nrst1), .core_data(data1),
        .busy(busy1), .done(done1), .rd_valid(v1), .rd_ready(rdy1), .rd_data(d1),
        .rd_ts(ts1), .rd_run(run1), .overflow(ov1));

    core_run_monitor #(.TS_W(4), .RUN_CYCLES(20)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .core_nrst(nrst2), .core_data(data2),
        .busy(busy2), .done(done2), .rd_valid(v2), .rd_ready(rdy2), .rd_data(d2),
        .rd_ts(ts2), .rd_run(run2), .overflow(ov2));

    int checks = 0;
    int failures = 0;
    int hi_cnt, lo_cnt, rise_cnt, done_cnt;
    int t, rc;
    logic pn, tg;
    bit fin;
    int er[$], et[$], ed[$];
    logic [5:0] samp [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ent(input string tag, input int i, input int r, input int ts, input int d);
        chk({tag, "_run"}, 32'(er[i]), 32'(r));
        chk({tag, "_ts"},  32'(et[i]), 32'(ts));
        chk({tag, "_data"}, 32'(ed[i]), 32'(d));
    endtask

    task automatic pop0(input string tag, input int r, input int ts, input int d);
        chk({tag, "_valid"}, 32'(v0), 1);
        chk({tag, "_run"},  32'(run0), 32'(r));
        chk({tag, "_ts"},   32'(ts0), 32'(ts));
        chk({tag, "_data"}, 32'(d0), 32'(d));
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
    endtask

    function automatic logic [5:0] pat_data(input int pat, input int r, input int tt);
        if (pat == 2) return (r > 0 || tt >= 20) ? 6'd7 : ((tt >= 10) ? 6'd3 : 6'd0);
        if (pat == 5) return 6'd2;
        return 6'd5;
    endfunction

    // Runs one full sequence on dut0 while tracking core_nrst phases from the outside.
    task automatic seq0(input int pat);
        int tt;
        logic p;
        bit f;
        tt = 0; p = 1'b0; f = 1'b0;
        hi_cnt = 0; lo_cnt = 0; rise_cnt = 0; done_cnt = 0;
        er.delete(); et.delete(); ed.delete();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 400 && !f; c++) begin
            if (nrst0) begin
                if (!p) begin rise_cnt++; tt = 0; end
                else tt++;
                hi_cnt++;
            end else if (busy0) lo_cnt++;
            p = nrst0;
            data0  = pat_data(pat, rise_cnt - 1, tt);
            start0 = (pat == 5 && (c == 1 || c == 30 || c == 60));
            if (v0 && rdy0) begin
                er.push_back(int'(run0)); et.push_back(int'(ts0)); ed.push_back(int'(d0));
            end
            if (done0) begin done_cnt++; f = 1'b1; end
            tick();
        end
        start0 = 1'b0;
        chk("seq_done_seen", 32'(f), 1);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 0; rdy0 = 0; data0 = 0;
        start1 = 0; rdy1 = 0; data1 = 0;
        start2 = 0; rdy2 = 0; data2 = 0;
        #12;
        chk("rst_nrst", 32'(nrst0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_valid", 32'(v0), 0);
        chk("rst_ovf", 32'(ov0), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // constant data, reader stalled: one entry per run
        rdy0 = 1'b0;
        seq0(1);
        chk("t1_high_cycles", 32'(hi_cnt), 100);
        chk("t1_low_cycles", 32'(lo_cnt), 4);
        chk("t1_runs", 32'(rise_cnt), 2);
        chk("t1_done_cnt", 32'(done_cnt), 1);
        chk("t1_busy_after", 32'(busy0), 0);
        chk("t1_nrst_idle", 32'(nrst0), 0);
        tick();
        chk("t1_hold_stable_ts", 32'(ts0), 0);
        pop0("t1_e0", 0, 0, 5);
        pop0("t1_e1", 1, 0, 5);
        chk("t1_empty", 32'(v0), 0);

        // stepped data with the reader always ready
        rdy0 = 1'b1;
        seq0(2);
        rdy0 = 1'b0;
        chk("t2_count", 32'(er.size()), 4);
        chk_ent("t2_e0", 0, 0, 0, 0);
        chk_ent("t2_e1", 1, 0, 10, 3);
        chk_ent("t2_e2", 2, 0, 20, 7);
        chk_ent("t2_e3", 3, 1, 0, 7);

        // toggling data into a 4-deep FIFO with no reader
        rdy1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        t = 0; rc = 0; pn = 1'b0; fin = 1'b0; tg = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (nrst1) begin
                if (!pn) begin rc++; t = 0; end
                else t++;
            end
            pn = nrst1;
            tg = ~tg;
            data1 = tg ? 6'd9 : 6'd4;
            if (nrst1 && rc == 1 && t < 4) samp[t] = data1;
            if (nrst1 && rc == 1 && t == 4) chk("t3_full_no_ovf", 32'(ov1), 0);
            if (nrst1 && rc == 1 && t == 5) chk("t3_ovf_set", 32'(ov1), 1);
            if (done1) fin = 1'b1;
            tick();
        end
        chk("t3_done_seen", 32'(fin), 1);
        chk("t3_ovf_sticky", 32'(ov1), 1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_valid", 32'(v1), 1);
            chk("t3_drain_run", 32'(run1), 0);
            chk("t3_drain_ts", 32'(ts1), 32'(i));
            chk("t3_drain_data", 32'(d1), 32'(samp[i]));
            rdy1 = 1'b1;
            tick();
            rdy1 = 1'b0;
        end
        chk("t3_drained", 32'(v1), 0);
        chk("t3_ovf_kept", 32'(ov1), 1);

        // full FIFO: pop and push in the same cycle, no drop
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t6_start_clr_ovf", 32'(ov1), 0);
        chk("t6_start_clr_fifo", 32'(v1), 0);
        er.delete(); et.delete(); ed.delete();
        t = 0; rc = 0; pn = 1'b0; fin = 1'b0; tg = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (nrst1) begin
                if (!pn) begin rc++; t = 0; end
                else t++;
            end
            pn = nrst1;
            if (nrst1 && rc == 1 && t <= 4) begin
                tg = ~tg;
                data1 = tg ? 6'd9 : 6'd4;
            end
            if (nrst1 && rc == 1 && t == 4) begin
                samp[4] = data1;
                chk("t6_full_head", 32'(ts1), 0);
                chk("t6_full_no_ovf", 32'(ov1), 0);
            end
            if (nrst1 && rc == 1 && t == 5) begin
                chk("t6_after_ovf", 32'(ov1), 0);
                chk("t6_after_head", 32'(ts1), 1);
            end
            rdy1 = (rc >= 2) || (rc == 1 && (!nrst1 || t == 4 || t >= 6));
            if (v1 && rdy1) begin
                er.push_back(int'(run1)); et.push_back(int'(ts1)); ed.push_back(int'(d1));
            end
            if (done1) fin = 1'b1;
            tick();
        end
        rdy1 = 1'b0;
        chk("t6_done_seen", 32'(fin), 1);
        chk("t6_count", 32'(er.size()), 6);
        chk_ent("t6_e4", 4, 0, 4, int'(samp[4]));
        chk_ent("t6_e5", 5, 1, 0, int'(samp[4]));
        chk("t6_ovf_end", 32'(ov1), 0);

        // timestamp saturation with TS_W=4
        rdy2 = 1'b1;
        er.delete(); et.delete(); ed.delete();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        t = 0; rc = 0; pn = 1'b0; fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (nrst2) begin
                if (!pn) begin rc++; t = 0; end
                else t++;
            end
            pn = nrst2;
            data2 = (rc >= 2 || (rc == 1 && t >= 18)) ? 6'd9 : 6'd0;
            if (v2 && rdy2) begin
                er.push_back(int'(run2)); et.push_back(int'(ts2)); ed.push_back(int'(d2));
            end
            if (done2) fin = 1'b1;
            tick();
        end
        rdy2 = 1'b0;
        chk("t6b_done_seen", 32'(fin), 1);
        chk("t6b_count", 32'(er.size()), 3);
        chk_ent("t6b_e0", 0, 0, 0, 0);
        chk_ent("t6b_e1", 1, 0, 15, 9);
        chk_ent("t6b_e2", 2, 1, 0, 9);

        // asynchronous reset in the middle of run 0
        rdy0 = 1'b0;
        data0 = 6'd1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        t = 0; pn = 1'b0; fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (nrst0) begin
                if (!pn) t = 0;
                else t++;
            end
            pn = nrst0;
            if (nrst0 && t == 25) fin = 1'b1;
            else tick();
        end
        chk("t4_reach_ts25", 32'(fin), 1);
        chk("t4_valid_before", 32'(v0), 1);
        rst = 1'b1;
        #1;
        chk("t4_nrst", 32'(nrst0), 0);
        chk("t4_busy", 32'(busy0), 0);
        chk("t4_fifo_empty", 32'(v0), 0);
        chk("t4_ovf", 32'(ov0), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // clean rerun with start pulses during busy
        rdy0 = 1'b1;
        seq0(5);
        rdy0 = 1'b0;
        chk("t5_high_cycles", 32'(hi_cnt), 100);
        chk("t5_runs", 32'(rise_cnt), 2);
        chk("t5_done_cnt", 32'(done_cnt), 1);
        chk("t5_count", 32'(er.size()), 2);
        chk_ent("t5_e0", 0, 0, 0, 2);
        chk_ent("t5_e1", 1, 1, 0, 2);
        for (int i = 0; i < 3; i++) begin
            if (done0) done_cnt++;
            tick();
        end
        chk("t5_no_extra_done", 32'(done_cnt), 1);
        chk("t5_idle_busy", 32'(busy0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
